// File: rtl/stream_demux.sv
// Steers a merged, dest-tagged valid/ready packet stream to STREAM_COUNT outputs, each behind a 2-entry buffer.
// Optional feature: define STREAM_DEMUX_DROP_CNT_EN to add the saturating drop_cnt port.
module stream_demux #(
    parameter int STREAM_COUNT  = 2,
    parameter int T_DATA__WIDTH = 8,
    parameter int T_QOS__WIDTH  = 4,
    parameter int T_DEST__WIDTH = $clog2(STREAM_COUNT) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [T_DATA__WIDTH-1:0] s_data,
    input  logic [T_DEST__WIDTH-1:0] s_dest,
    input  logic [T_QOS__WIDTH-1:0]  s_qos,
    input  logic                     s_last,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [T_DATA__WIDTH-1:0] m_data [STREAM_COUNT],
    output logic [T_QOS__WIDTH-1:0]  m_qos  [STREAM_COUNT],
    output logic                     m_last [STREAM_COUNT],
    output logic [STREAM_COUNT-1:0]  m_valid,
    input  logic [STREAM_COUNT-1:0]  m_ready
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t state, next_state;

    logic [T_DEST__WIDTH-1:0] dest_q;
    logic [T_QOS__WIDTH-1:0]  qos_q;

    logic [T_DATA__WIDTH-1:0] fifo_data [STREAM_COUNT][2];
    logic [T_QOS__WIDTH-1:0]  fifo_qos  [STREAM_COUNT][2];
    logic                     fifo_last [STREAM_COUNT][2];
    logic                     rd_ptr    [STREAM_COUNT];
    logic                     wr_ptr    [STREAM_COUNT];
    logic [1:0]               count     [STREAM_COUNT];

    logic [T_DEST__WIDTH-1:0] target;
    logic [T_QOS__WIDTH-1:0]  wr_qos;
    logic [STREAM_COUNT-1:0]  sel, full, wr_en, rd_en;
    logic                     target_valid, target_full, handshake;

    // The head beat routes on the live s_dest; later beats reuse the latched one.
    always_comb begin
        target = (state == IDLE) ? s_dest : dest_q;
        wr_qos = (state == IDLE) ? s_qos : qos_q;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            sel[i]   = (target == T_DEST__WIDTH'(i));
            full[i]  = (count[i] == 2'd2);
            rd_en[i] = m_valid[i] & m_ready[i];
        end
        target_valid = |sel;
        target_full  = |(sel & full);
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        wr_en      = '0;
        case (state)
            IDLE:    s_ready = target_valid ? !target_full : 1'b1;
            PASS:    s_ready = !target_full;
            DROP:    s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
        if (rst) begin
            s_ready = 1'b0;
        end
        handshake = s_valid & s_ready;
        if (handshake) begin
            case (state)
                IDLE: begin
                    if (target_valid) begin
                        wr_en = sel;
                        if (!s_last) next_state = PASS;
                    end else if (!s_last) begin
                        next_state = DROP;
                    end
                end
                PASS: begin
                    wr_en = sel;
                    if (s_last) next_state = IDLE;
                end
                DROP: if (s_last) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dest_q <= '0;
            qos_q  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && handshake) begin
                dest_q <= s_dest;
                qos_q  <= s_qos;
            end
        end
    end

    // Each output buffer is a 2-deep ring; reads and writes are independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STREAM_COUNT; i++) begin
                rd_ptr[i] <= 1'b0;
                wr_ptr[i] <= 1'b0;
                count[i]  <= 2'd0;
                for (int j = 0; j < 2; j++) begin
                    fifo_data[i][j] <= '0;
                    fifo_qos[i][j]  <= '0;
                    fifo_last[i][j] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < STREAM_COUNT; i++) begin
                if (wr_en[i]) begin
                    fifo_data[i][wr_ptr[i]] <= s_data;
                    fifo_qos[i][wr_ptr[i]]  <= wr_qos;
                    fifo_last[i][wr_ptr[i]] <= s_last;
                    wr_ptr[i]               <= ~wr_ptr[i];
                end
                if (rd_en[i]) begin
                    rd_ptr[i] <= ~rd_ptr[i];
                end
                count[i] <= count[i] + 2'(wr_en[i]) - 2'(rd_en[i]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < STREAM_COUNT; i++) begin
            m_valid[i] = (count[i] != 2'd0);
            m_data[i]  = fifo_data[i][rd_ptr[i]];
            m_qos[i]   = fifo_qos[i][rd_ptr[i]];
            m_last[i]  = fifo_last[i][rd_ptr[i]];
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic drop_head;
    assign drop_head = (state == IDLE) && handshake && !target_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'd0;
        end else if (drop_head && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux with two outputs; drop_cnt is checked when STREAM_DEMUX_DROP_CNT_EN is defined.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic [1:0] s_dest = '0;
    logic [3:0] s_qos = '0;
    logic       s_last = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] m_data [2];
    logic [3:0] m_qos [2];
    logic       m_last [2];
    logic [1:0] m_valid;
    logic [1:0] m_ready = '0;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];

    stream_demux dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_dest  (s_dest),
        .s_qos   (s_qos),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_qos   (m_qos),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change just after rising edges, so the falling edge shows what the next edge will consume.
    always @(negedge clk) begin
        if (!rst && m_valid[0] && m_ready[0]) rx0.push_back(m_data[0]);
        if (!rst && m_valid[1] && m_ready[1]) rx1.push_back(m_data[1]);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] dest, input logic [7:0] data,
                                 input logic [3:0] qos, input logic last);
        bit done = 0;
        s_valid = 1'b1;
        s_dest  = dest;
        s_data  = data;
        s_qos   = qos;
        s_last  = last;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            done = s_ready;
            tick();
        end
        if (!done) checkOutput("beat_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    initial begin
        // Reset held with s_valid high.
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("rst_ready", 32'(s_ready), 0);
            checkOutput("rst_valid", 32'(m_valid), 0);
        end
        checkOutput("rst_data0", 32'(m_data[0]), 0);
        checkOutput("rst_last1", 32'(m_last[1]), 0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        checkOutput("rst_drop", 32'(drop_cnt), 0);
`endif
        rst = 1'b0;
        s_valid = 1'b0;
        tick();

        // Single-beat packet to output 1.
        s_dest = 2'd1; s_data = 8'hA5; s_qos = 4'd7; s_last = 1'b1; s_valid = 1'b1;
        #1;
        checkOutput("single_ready", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        checkOutput("single_valid", 32'(m_valid), 32'h2);
        checkOutput("single_data", 32'(m_data[1]), 32'hA5);
        checkOutput("single_qos", 32'(m_qos[1]), 7);
        checkOutput("single_last", 32'(m_last[1]), 1);
        m_ready = 2'b10;
        tick();
        m_ready = 2'b00;
        checkOutput("single_drained", 32'(m_valid), 0);
        checkOutput("single_rx", 32'(rx1.size()), 1);
        rx1.delete();

        // Backpressure: output 0 stalled fills after two beats.
        applyStimulus(2'd0, 8'h10, 4'd3, 1'b0);
        applyStimulus(2'd0, 8'h11, 4'd0, 1'b0);
        s_data = 8'h12; s_last = 1'b0; s_valid = 1'b1;
        #1;
        checkOutput("bp_ready_full", 32'(s_ready), 0);
        tick();
        checkOutput("bp_still_full", 32'(s_ready), 0);
        checkOutput("bp_head", 32'(m_data[0]), 32'h10);
        checkOutput("bp_head_qos", 32'(m_qos[0]), 3);
        m_ready = 2'b01;
        #1;
        checkOutput("bp_no_comb_path", 32'(s_ready), 0);
        tick();
        applyStimulus(2'd0, 8'h12, 4'd0, 1'b0);
        applyStimulus(2'd3, 8'h13, 4'd0, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        m_ready = 2'b00;
        checkOutput("bp_count", 32'(rx0.size()), 4);
        for (int k = 0; k < 4 && k < rx0.size(); k++)
            checkOutput($sformatf("bp_order%0d", k), 32'(rx0[k]), 32'h10 + k);
        checkOutput("bp_empty", 32'(m_valid), 0);
        rx0.delete();

        // Output 0 full must not block a packet to output 1.
        applyStimulus(2'd0, 8'h20, 4'd1, 1'b0);
        applyStimulus(2'd0, 8'h21, 4'd1, 1'b1);
        s_dest = 2'd1; s_data = 8'h30; s_qos = 4'd2; s_last = 1'b1; s_valid = 1'b1;
        #1;
        checkOutput("indep_ready", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        checkOutput("indep_valid", 32'(m_valid), 32'h3);
        checkOutput("indep_data1", 32'(m_data[1]), 32'h30);
        checkOutput("indep_data0", 32'(m_data[0]), 32'h20);
        m_ready = 2'b11;
        for (int k = 0; k < 3; k++) tick();
        m_ready = 2'b00;
        checkOutput("indep_rx0", 32'(rx0.size()), 2);
        checkOutput("indep_rx1", 32'(rx1.size()), 1);
        rx0.delete();
        rx1.delete();

        // Invalid destination: three beats discarded; later beats carry a valid dest that must be ignored.
        for (int k = 0; k < 3; k++) begin
            s_dest = (k == 0) ? 2'd3 : 2'd0;
            s_data = 8'hE0 + 8'(k); s_last = (k == 2); s_valid = 1'b1;
            #1;
            checkOutput($sformatf("drop_ready%0d", k), 32'(s_ready), 1);
            tick();
            checkOutput($sformatf("drop_valid%0d", k), 32'(m_valid), 0);
        end
        s_valid = 1'b0;
`ifdef STREAM_DEMUX_DROP_CNT_EN
        checkOutput("drop_cnt", 32'(drop_cnt), 1);
`endif
        applyStimulus(2'd0, 8'h40, 4'd5, 1'b1);
        checkOutput("after_drop_valid", 32'(m_valid), 32'h1);
        checkOutput("after_drop_data", 32'(m_data[0]), 32'h40);
        checkOutput("after_drop_qos", 32'(m_qos[0]), 5);
        m_ready = 2'b01;
        tick();
        m_ready = 2'b00;
        rx0.delete();

        // Reset in the middle of a packet to output 1.
        applyStimulus(2'd1, 8'h50, 4'd4, 1'b0);
        applyStimulus(2'd1, 8'h51, 4'd4, 1'b0);
        checkOutput("mid_pre_valid", 32'(m_valid), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_valid", 32'(m_valid), 0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        checkOutput("mid_rst_drop", 32'(drop_cnt), 0);
`endif
        applyStimulus(2'd0, 8'h60, 4'd9, 1'b1);
        checkOutput("mid_new_valid", 32'(m_valid), 32'h1);
        checkOutput("mid_new_data", 32'(m_data[0]), 32'h60);
        checkOutput("mid_new_last", 32'(m_last[0]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
